// File: rtl/tag_rf_pkg.sv
// Shared types, default parameters and helpers for the tagged register file.
package tag_rf_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_TAG_W    = 4;
    localparam int DEF_DEPTH    = 32;
    localparam int DEF_N_RD     = 2;
    localparam int DEF_ZERO_REG = 1;
    localparam int DEF_BYPASS   = 1;

    // Width able to hold any count in [0, depth].
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/tag_rf_clear_fsm.sv
// Clear sweep controller: walks every entry once after reset or a clear
// request, then holds IDLE and grants writes.
module tag_rf_clear_fsm
    import tag_rf_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_n,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o,
    output logic              wr_ready_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_ptr_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    rf_state_e         state;
    logic [ADDR_W-1:0] ptr;

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_CLEAR;
            ptr        <= '0;
            clr_busy_o <= 1'b1;
            clr_done_o <= 1'b0;
            wr_ready_o <= 1'b0;
        end else begin
            clr_done_o <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (ptr == LAST) begin
                        state      <= ST_IDLE;
                        ptr        <= '0;
                        clr_busy_o <= 1'b0;
                        clr_done_o <= 1'b1;
                        wr_ready_o <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr_req_i) begin
                        state      <= ST_CLEAR;
                        ptr        <= '0;
                        clr_busy_o <= 1'b1;
                        wr_ready_o <= 1'b0;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign clr_we_o  = (state == ST_CLEAR);
    assign clr_ptr_o = ptr;

endmodule

// File: rtl/tag_reg_file.sv
// Register file with a per-entry fault tag, N combinational read ports,
// a monitor port, optional zero register and write-to-read bypass.
module tag_reg_file
    import tag_rf_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TAG_W    = DEF_TAG_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int N_RD     = DEF_N_RD,
    parameter int ZERO_REG = DEF_ZERO_REG,
    parameter int BYPASS   = DEF_BYPASS
) (
    input  logic                     clk_i,
    input  logic                     reset_n,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [N_RD*DATA_W-1:0]   rd_data_o,
    output logic [N_RD*TAG_W-1:0]    rd_tag_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic [TAG_W-1:0]         wr_tag_i,
    output logic                     wr_ready_o,
    input  logic [ADDR_W-1:0]        mon_addr_i,
    output logic [DATA_W-1:0]        mon_data_o,
    output logic [TAG_W-1:0]         mon_tag_o,
    input  logic                     clr_req_i,
    output logic                     clr_busy_o,
    output logic                     clr_done_o,
    output logic [cnt_w(DEPTH)-1:0]  tagged_cnt_o
);

    localparam int              CNT_W   = cnt_w(DEPTH);
    localparam int              WORD_W  = TAG_W + DATA_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0]  mem_tag  [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_ptr;
    logic              wr_acc;
    logic              wr_commit;

    tag_rf_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .clr_req_i  (clr_req_i),
        .clr_busy_o (clr_busy_o),
        .clr_done_o (clr_done_o),
        .wr_ready_o (wr_ready_o),
        .clr_we_o   (clr_we),
        .clr_ptr_o  (clr_ptr)
    );

    // An address is live when it maps to a real, writable entry.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [WORD_W-1:0] lookup(input logic [ADDR_W-1:0] a);
        if (clr_busy_o || !addr_live(a))
            return '0;
        if ((BYPASS != 0) && wr_acc && (wr_addr_i == a))
            return {wr_tag_i, wr_data_i};
        return {mem_tag[a], mem_data[a]};
    endfunction

    assign wr_acc    = wr_en_i & wr_ready_o;
    assign wr_commit = wr_acc & addr_live(wr_addr_i);

    // Array holds data only; its contents become defined through the sweep.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem_data[clr_ptr] <= '0;
            mem_tag[clr_ptr]  <= '0;
        end else if (wr_commit) begin
            mem_data[wr_addr_i] <= wr_data_i;
            mem_tag[wr_addr_i]  <= wr_tag_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n)
            tagged_cnt_o <= '0;
        else if (wr_ready_o && clr_req_i)
            tagged_cnt_o <= '0;
        else if (wr_commit)
            tagged_cnt_o <= tagged_cnt_o + CNT_W'(|wr_tag_i) - CNT_W'(|mem_tag[wr_addr_i]);
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [WORD_W-1:0] word;
        always_comb word = lookup(rd_addr_i[k*ADDR_W +: ADDR_W]);
        assign rd_data_o[k*DATA_W +: DATA_W] = word[DATA_W-1:0];
        assign rd_tag_o[k*TAG_W +: TAG_W]    = word[DATA_W +: TAG_W];
    end

    logic [WORD_W-1:0] mon_word;
    always_comb mon_word = lookup(mon_addr_i);
    assign mon_data_o = mon_word[DATA_W-1:0];
    assign mon_tag_o  = mon_word[DATA_W +: TAG_W];

endmodule
